// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared op/state types and helpers for the load/store master
// Misalignment helper is only consulted when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } lsu_op_t;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_WORD = 2'd1;
  localparam logic [1:0] MW_BYTE = 2'd2;
  localparam logic [1:0] MW_HALF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  function automatic logic is_store(input lsu_op_t op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] lo);
    case (op)
      LW, SW:      return lo != 2'b00;
      LH, LHU, SH: return lo[0];
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] mw_code(input lsu_op_t op);
    case (op)
      SW:      return MW_WORD;
      SH:      return MW_HALF;
      SB:      return MW_BYTE;
      default: return MW_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_load_align.sv
// rtl/lsu_mem_master_load_align.sv - big-endian lane select and sign/zero extend
// Purely combinational; word index already chosen by the memory from dataadr.
module load_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   op,
  input  logic [1:0]   addr_lo,
  input  logic [N-1:0] readdata,
  output logic [N-1:0] rdata
);

  lsu_op_t    op_e;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign op_e = lsu_op_t'(op);

  always_comb begin
    // Lane 00 is the most significant byte of the word.
    case (addr_lo)
      2'b00:   byte_sel = readdata[31:24];
      2'b01:   byte_sel = readdata[23:16];
      2'b10:   byte_sel = readdata[15:8];
      default: byte_sel = readdata[7:0];
    endcase
    half_sel = addr_lo[1] ? readdata[15:0] : readdata[31:16];

    case (op_e)
      LW:      rdata = readdata;
      LH:      rdata = {{(N-16){half_sel[15]}}, half_sel};
      LHU:     rdata = {{(N-16){1'b0}}, half_sel};
      LB:      rdata = {{(N-8){byte_sel[7]}}, byte_sel};
      LBU:     rdata = {{(N-8){1'b0}}, byte_sel};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - single-outstanding load/store initiator (IDLE->ACCESS->RESP)
// Optional LSU_MISALIGN_TRAP_EN: misaligned ops skip the write and respond with resp_err.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic [N-1:0] dataadr,
  output logic [N-1:0] writedata,
  output logic [1:0]   memwrite,
  input  logic [N-1:0] readdata
);

  lsu_state_t   state;
  lsu_op_t      op_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] rdata_q;
  logic         err_q;
  logic [N-1:0] align_rdata;
  logic         trap;

  load_align #(.N(N)) u_load_align (
    .op       (op_q),
    .addr_lo  (addr_q[1:0]),
    .readdata (readdata),
    .rdata    (align_rdata)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(op_q, addr_q[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= lsu_op_t'(req_op);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rdata_q <= (is_store(op_q) || trap) ? '0 : align_rdata;
          err_q   <= trap;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dataadr    = addr_q;
  assign writedata  = wdata_q;

  // Gating with reset lets a reset raised mid-ACCESS suppress the write edge.
  assign memwrite = (state == ST_ACCESS && !trap && !reset) ? mw_code(op_q) : MW_NONE;

endmodule
